// File: rtl/microwave_cook_timer_if.sv
// microwave_cook_timer_if: keypad/door inputs and timer outputs of the cook timer
interface microwave_cook_timer_if #(parameter int TIME_W = 12);
  logic door_closed;
  logic load;
  logic [TIME_W-1:0] time_in;
  logic start;
  logic cancel;
  logic [TIME_W-1:0] remaining;
  logic magnetron_en;
  logic done;
  logic beep;
  logic [2:0] state;
  modport master (
    output door_closed, load, time_in, start, cancel,
    input  remaining, magnetron_en, done, beep, state
  );
  modport slave (
    input  door_closed, load, time_in, start, cancel,
    output remaining, magnetron_en, done, beep, state
  );
endinterface

// File: rtl/microwave_cook_timer.sv
// microwave_cook_timer: cook-time countdown, magnetron gating, expiry pulse and beeper
module microwave_cook_timer #(
  parameter int CLK_PER_SEC = 100,
  parameter int TIME_W      = 12,
  parameter int BEEP_SEC    = 3
) (
  input logic clk,
  input logic sys_reset,
  microwave_cook_timer_if.slave bus
);
  localparam int PW = $clog2(CLK_PER_SEC);
  localparam int BW = $clog2(BEEP_SEC + 1);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    BEEP  = 3'd4
  } state_t;
  state_t state, state_n;
  logic [TIME_W-1:0] rem, rem_n;
  logic [PW-1:0] psc, psc_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic done_n, done_r, mag_r, beep_r;
  logic tick, go;
  assign tick = psc == PW'(CLK_PER_SEC - 1);
  assign go   = bus.start && bus.door_closed;
  always_comb begin
    state_n = state;
    rem_n   = rem;
    psc_n   = psc;
    bcnt_n  = bcnt;
    done_n  = 1'b0;
    case (state)
      IDLE: if (bus.load) begin
        rem_n   = bus.time_in;
        state_n = bus.time_in != '0 ? ARMED : IDLE;
      end
      ARMED: if (bus.cancel) begin
        state_n = IDLE;
        rem_n   = '0;
      end else if (bus.load) begin
        rem_n   = bus.time_in;
        state_n = bus.time_in != '0 ? ARMED : IDLE;
      end else if (go) begin
        state_n = COOK;
        psc_n   = '0;
      end
      COOK: if (bus.cancel) begin
        state_n = IDLE;
        rem_n   = '0;
        psc_n   = '0;
      end else if (!bus.door_closed) begin
        state_n = PAUSE;
      end else if (tick) begin
        psc_n = '0;
        if (rem == TIME_W'(1)) begin
          rem_n   = '0;
          done_n  = 1'b1;
          state_n = BEEP;
          bcnt_n  = '0;
        end else if (rem != '0) begin
          rem_n = rem - TIME_W'(1);
        end
      end else begin
        psc_n = psc + PW'(1);
      end
      PAUSE: if (bus.cancel) begin
        state_n = IDLE;
        rem_n   = '0;
        psc_n   = '0;
      end else if (go) begin
        state_n = COOK;
      end
      BEEP: if (bus.cancel) begin
        state_n = IDLE;
        psc_n   = '0;
      end else if (tick) begin
        psc_n   = '0;
        bcnt_n  = bcnt + BW'(1);
        state_n = bcnt == BW'(BEEP_SEC - 1) ? IDLE : BEEP;
      end else begin
        psc_n = psc + PW'(1);
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (sys_reset) begin
      state  <= IDLE;
      rem    <= '0;
      psc    <= '0;
      bcnt   <= '0;
      done_r <= 1'b0;
      mag_r  <= 1'b0;
      beep_r <= 1'b0;
    end else begin
      state  <= state_n;
      rem    <= rem_n;
      psc    <= psc_n;
      bcnt   <= bcnt_n;
      done_r <= done_n;
      mag_r  <= state_n == COOK;
      beep_r <= state_n == BEEP;
    end
  end
  assign bus.remaining    = rem;
  assign bus.magnetron_en = mag_r;
  assign bus.done         = done_r;
  assign bus.beep         = beep_r;
  assign bus.state        = state;
endmodule

// File: tb/tb_microwave_cook_timer.sv
// tb_microwave_cook_timer: directed stimulus with a cycle-stamped expectation queue checked by a monitor
module tb_microwave_cook_timer;
  logic clk = 1'b0;
  logic sys_reset = 1'b1;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int done_seen = 0;
  int done_exp = 0;
  typedef struct {
    int cyc;
    string name;
    logic [11:0] rem;
    logic mag;
    logic dn;
    logic bp;
    logic [2:0] st;
  } exp_t;
  exp_t q[$];
  microwave_cook_timer_if #(.TIME_W(12)) bus ();
  microwave_cook_timer #(.CLK_PER_SEC(4), .TIME_W(12), .BEEP_SEC(2)) dut (
    .clk(clk), .sys_reset(sys_reset), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.done === 1'b1) done_seen++;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      if ({bus.remaining, bus.magnetron_en, bus.done, bus.beep, bus.state} !==
          {e.rem, e.mag, e.dn, e.bp, e.st}) begin
        fails++;
        $display("FAIL %s @%0d: got rem=%0d mag=%0b done=%0b beep=%0b st=%0d, want rem=%0d mag=%0b done=%0b beep=%0b st=%0d",
                 e.name, cyc, bus.remaining, bus.magnetron_en, bus.done, bus.beep, bus.state,
                 e.rem, e.mag, e.dn, e.bp, e.st);
      end
    end
  end
  function automatic void expect_out(string n, int rem, logic mag, logic dn, logic bp, int st);
    exp_t e;
    e.cyc = cyc; e.name = n; e.rem = 12'(rem); e.mag = mag; e.dn = dn; e.bp = bp; e.st = 3'(st);
    q.push_back(e);
    if (dn) done_exp++;
  endfunction
  task automatic step(input logic l = 1'b0, input int t = 0, input logic s = 1'b0, input logic c = 1'b0);
    bus.load = l; bus.time_in = 12'(t); bus.start = s; bus.cancel = c;
    @(posedge clk);
    #1;
    bus.load = 1'b0; bus.start = 1'b0; bus.cancel = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, required completion before 200000");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.door_closed = 1'b1;
    bus.load = 1'b0; bus.time_in = '0; bus.start = 1'b0; bus.cancel = 1'b0;
    // 1: reset and idle
    step(); step();
    expect_out("reset", 0, 0, 0, 0, 0);
    sys_reset = 1'b0;
    step(.s(1'b1));
    expect_out("idle_start", 0, 0, 0, 0, 0);
    // 2: basic cook to expiry and beep
    step(.l(1'b1), .t(3));
    expect_out("load3", 3, 0, 0, 0, 1);
    step(.s(1'b1));
    expect_out("cook_enter", 3, 1, 0, 0, 2);
    for (int i = 1; i < 12; i++) begin
      step();
      expect_out($sformatf("count_%0d", i), 3 - i / 4, 1, 0, 0, 2);
    end
    step();
    expect_out("expire", 0, 0, 1, 1, 4);
    for (int i = 1; i < 8; i++) begin
      step();
      expect_out($sformatf("beep_%0d", i), 0, 0, 0, 1, 4);
    end
    step();
    expect_out("beep_end", 0, 0, 0, 0, 0);
    // 3: pause and resume
    step(.l(1'b1), .t(3));
    step(.s(1'b1));
    repeat (4) step();
    expect_out("sec2", 2, 1, 0, 0, 2);
    step(); step();
    bus.door_closed = 1'b0;
    step();
    expect_out("pause", 2, 0, 0, 0, 3);
    step(.s(1'b1));
    expect_out("pause_open_start", 2, 0, 0, 0, 3);
    bus.door_closed = 1'b1;
    repeat (3) step();
    expect_out("pause_closed", 2, 0, 0, 0, 3);
    step(.l(1'b1), .t(9));
    expect_out("pause_load", 2, 0, 0, 0, 3);
    step(.s(1'b1));
    expect_out("resume", 2, 1, 0, 0, 2);
    step();
    expect_out("resume_1", 2, 1, 0, 0, 2);
    step();
    expect_out("resume_2", 1, 1, 0, 0, 2);
    // 4: cancel mid-cook and during beep
    step(.c(1'b1));
    expect_out("cancel_cook", 0, 0, 0, 0, 0);
    step(.l(1'b1), .t(1));
    step(.s(1'b1));
    repeat (3) step();
    expect_out("last_sec", 1, 1, 0, 0, 2);
    step();
    expect_out("expire2", 0, 0, 1, 1, 4);
    step();
    expect_out("beep2", 0, 0, 0, 1, 4);
    step(.c(1'b1));
    expect_out("cancel_beep", 0, 0, 0, 0, 0);
    // 5: simultaneous events in ARMED
    step(.l(1'b1), .t(4));
    expect_out("armed4", 4, 0, 0, 0, 1);
    step(.l(1'b1), .t(5), .s(1'b1));
    expect_out("load_start", 5, 0, 0, 0, 1);
    step(.s(1'b1), .c(1'b1));
    expect_out("cancel_start", 0, 0, 0, 0, 0);
    step(.l(1'b1), .t(2));
    bus.door_closed = 1'b0;
    step(.s(1'b1));
    expect_out("start_door_open", 2, 0, 0, 0, 1);
    bus.door_closed = 1'b1;
    step(.l(1'b1), .t(0));
    expect_out("armed_load0", 0, 0, 0, 0, 0);
    // 6: reset mid-cook
    step(.l(1'b1), .t(7));
    step(.s(1'b1));
    step(); step();
    expect_out("cook7", 7, 1, 0, 0, 2);
    sys_reset = 1'b1;
    step();
    expect_out("reset_mid", 0, 0, 0, 0, 0);
    sys_reset = 1'b0;
    step(.l(1'b1), .t(0));
    expect_out("idle_load0", 0, 0, 0, 0, 0);
    step(); step();
    tests++;
    if (done_seen != done_exp) begin
      fails++;
      $display("FAIL done_count: got %0d pulses, want %0d", done_seen, done_exp);
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: got %0d unchecked entries, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
